image_mem_reader: RTL and testbench
===================================

Name: image_mem_reader

Overview:
- Streaming read initiator for the byte-wide image memory used by the processor. The memory has an 18-bit address, reads on the negedge, and is write-enabled low for reads.
- On a start pulse, sweeps NUM_PIXELS consecutive addresses from BASE_ADDR and emits each byte on a valid/ready stream. The stream feeds downstream consumers such as a display or UART path.
- Sustains 1 byte/cycle when the consumer is always ready.

Parameters:
- ADDR_W, 18: memory address width.
- DATA_W, 8: pixel/byte width.
- NUM_PIXELS, 40000: bytes per sweep. Legal range is 1 to 2^ADDR_W.
- BASE_ADDR, 0: first address of the sweep. BASE_ADDR+NUM_PIXELS must be ≤ 2^ADDR_W.

Ports:
- clk, input, 1: system clock. All logic here is posedge; the memory samples on negedge.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle pulse that begins a sweep. Ignored unless the block is in IDLE.
- mem_a, output, ADDR_W: memory address.
- mem_we, output, 1: memory write enable. Constant 0.
- mem_rd, input, DATA_W: memory read data. Valid at the posedge following the cycle in which mem_a was presented.
- out_data, output, DATA_W: stream data.
- out_valid, output, 1: stream valid.
- out_ready, input, 1: stream ready from the consumer.
- out_last, output, 1: high together with out_valid on the final byte.
- busy, output, 1: high in PRIME and STREAM.
- done, output, 1: one-cycle pulse after the final byte handshake.
- checksum, output, 16: see Optional Feature.

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-sweep):
  - state=IDLE, mem_a=BASE_ADDR, idx=0.
  - out_data=0, out_valid=0, out_last=0, busy=0, done=0, checksum=0.
- Handshake:
  - A transfer occurs on any posedge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_last and mem_a hold stable. The memory re-reads the same address harmlessly.
  - out_valid never drops without a transfer.
- Counter: idx holds the number of bytes captured so far. mem_a = BASE_ADDR + idx, truncated to ADDR_W.
- State machine:
  - IDLE: mem_a=BASE_ADDR. If start=1, go to PRIME with idx=0.
  - PRIME (1 cycle): the memory returns mem_rd for BASE_ADDR. At the next posedge:
    - out_data<=mem_rd, out_valid<=1, out_last<=(NUM_PIXELS==1), idx<=1.
    - Go to STREAM.
  - STREAM, on a transfer:
    - If out_last=1: out_valid<=0, out_last<=0, go to DONE.
    - Otherwise: out_data<=mem_rd (the address already presented), idx<=idx+1, out_last<=(idx+1==NUM_PIXELS).
    - No transfer: hold everything.
  - DONE (1 cycle): done=1, busy=0. Go to IDLE. A start in this cycle is ignored.
- Latency:
  - start accepted at posedge T → first out_valid at T+2 → subsequent bytes one per cycle while ready=1.
  - done asserts the cycle after the last transfer.
- Boundaries:
  - start while busy: ignored, with no restart.
  - NUM_PIXELS=1: the first byte carries out_last.
  - The final address is BASE_ADDR+NUM_PIXELS-1. The address never advances past it; after the last capture mem_a holds the last address.
  - reset during STREAM aborts the sweep with no done pulse. A fresh start is required afterwards.

Optional Feature:
- Macro: IMG_READER_CHECKSUM_EN.
- Enabled:
  - checksum is a 16-bit modular sum of every transferred out_data.
  - It clears to 0 when start is accepted and updates on each transfer.
  - It is stable from done until the next start.
- Disabled: checksum is tied to 0 and no adder is synthesized.

Test Plan:
- Basic sweep: NUM_PIXELS=4, BASE_ADDR=0, memory holds 0x11,0x22,0x33,0x44, out_ready=1, start at cycle 0 → bytes 0x11..0x44 on cycles 2–5, out_last only with 0x44, done on cycle 6, busy on cycles 1–5.
- Backpressure: same setup, out_ready=0 on cycles 3–5 → 0x22 and mem_a=2 hold through cycle 5, then 0x33 and 0x44 follow, done after the 0x44 transfer. No byte is lost or duplicated.
- Offset/edge: BASE_ADDR=0x3FFFF, NUM_PIXELS=1, mem[0x3FFFF]=0xA5 → a single byte 0xA5 with out_last=1, and mem_a never wraps to 0.
- start during busy: pulse start again on cycle 3 of the basic sweep → the output sequence is unchanged and exactly one done pulse occurs.
- Reset mid-operation: assert reset on cycle 4 → out_valid=0, mem_a=0 and busy=0 immediately, no done. A new start yields the full sequence from 0x11.
- Checksum (IMG_READER_CHECKSUM_EN defined): bytes 0xFF×4 → checksum=0x03FC at done. Without the macro, checksum=0.

Source files
------------

// File: rtl/image_mem_reader.sv
// Streaming read initiator: sweeps NUM_PIXELS bytes from BASE_ADDR out of the image memory onto a valid/ready stream.
// Optional running checksum of transferred bytes is built only when IMG_READER_CHECKSUM_EN is defined.
module image_mem_reader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int NUM_PIXELS = 40000,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   NPIX     = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W:0]   LAST_IDX = NPIX - 1'b1;

  state_t          state;
  logic [ADDR_W:0] idx, idx_nx, idx_cl;
  logic            xfer;

  assign mem_we = 1'b0;
  assign xfer   = out_valid && out_ready;
  assign idx_nx = idx + 1'b1;
  // Address tracks idx but parks on the final pixel once everything has been captured.
  assign idx_cl = (idx_nx > LAST_IDX) ? LAST_IDX : idx_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_a     <= BASE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_a <= BASE;
          if (start) begin
            state <= PRIME;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        PRIME: begin
          out_data  <= mem_rd;
          out_valid <= 1'b1;
          out_last  <= (NPIX == 1);
          idx       <= idx_nx;
          mem_a     <= BASE + idx_cl[ADDR_W-1:0];
          state     <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              // mem_rd already reflects the address presented this cycle.
              out_data <= mem_rd;
              idx      <= idx_nx;
              out_last <= (idx_nx == NPIX);
              mem_a    <= BASE + idx_cl[ADDR_W-1:0];
            end
          end
        end
        default: begin
          done  <= 1'b0;
          mem_a <= BASE;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IMG_READER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      checksum <= '0;
    else if (state == IDLE && start)
      checksum <= '0;
    else if (state == STREAM && xfer)
      checksum <= checksum + 16'(out_data);
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_mem_reader.sv
// Scoreboard bench for image_mem_reader: a 4-byte sweep instance and a single-byte top-of-memory instance.
module tb_image_mem_reader;

  logic        clk, reset;
  logic        start_a, ready_a, start_b, ready_b;
  logic [17:0] a_addr, b_addr;
  logic        a_we, b_we;
  logic [7:0]  rd_a, rd_b, a_data, b_data;
  logic        a_valid, a_last, a_busy, a_done;
  logic        b_valid, b_last, b_busy, b_done;
  logic [15:0] a_sum, b_sum;

  int total = 0, bad = 0;
  int a_dones = 0, b_dones = 0;
  logic [8:0] qa[$], qb[$];
  logic [7:0] mem_img[4];

  image_mem_reader #(.ADDR_W(18), .DATA_W(8), .NUM_PIXELS(4), .BASE_ADDR(0)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .mem_a(a_addr), .mem_we(a_we), .mem_rd(rd_a),
    .out_data(a_data), .out_valid(a_valid), .out_ready(ready_a), .out_last(a_last),
    .busy(a_busy), .done(a_done), .checksum(a_sum));

  image_mem_reader #(.ADDR_W(18), .DATA_W(8), .NUM_PIXELS(1), .BASE_ADDR(18'h3FFFF)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mem_a(b_addr), .mem_we(b_we), .mem_rd(rd_b),
    .out_data(b_data), .out_valid(b_valid), .out_ready(ready_b), .out_last(b_last),
    .busy(b_busy), .done(b_done), .checksum(b_sum));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory reads on the negedge, so data is ready at the following posedge.
  always @(negedge clk) begin
    rd_a = (a_addr < 18'd4) ? mem_img[a_addr[1:0]] : 8'hEE;
    rd_b = (b_addr == 18'h3FFFF) ? 8'hA5 : 8'h00;
  end

  always @(negedge clk) begin
    if (a_valid && ready_a) begin
      if (qa.size() == 0) chk("a_extra", 1, 0);
      else chk("a_byte", {23'd0, a_last, a_data}, {23'd0, qa.pop_front()});
    end
    if (b_valid && ready_b) begin
      if (qb.size() == 0) chk("b_extra", 1, 0);
      else chk("b_byte", {23'd0, b_last, b_data}, {23'd0, qb.pop_front()});
    end
    if (a_done) a_dones++;
    if (b_done) b_dones++;
    chk("we", {30'd0, a_we, b_we}, 0);
  end

  task automatic sweep_a(input int stall_lo, input int stall_hi, input int restart_cyc, input bit timing);
    int d0;
    logic [15:0] s;
    bit seen;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      qa.push_back({(i == 3), mem_img[i]});
      s = s + 16'(mem_img[i]);
    end
`ifndef IMG_READER_CHECKSUM_EN
    s = 0;
`endif
    d0 = a_dones;
    seen = 0;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c < 40; c++) begin
      ready_a = !(c >= stall_lo && c <= stall_hi);
      start_a = (c == restart_cyc);
      @(negedge clk);
      if (timing) begin
        chk("a_busy", a_busy, c <= 5);
        chk("a_valid", a_valid, c >= 2 && c <= 5);
        chk("a_done", a_done, c == 6);
      end
      if (!ready_a && c >= 3) begin
        chk("stall_data", a_data, 8'h22);
        chk("stall_addr", a_addr, 2);
        chk("stall_valid", a_valid, 1);
      end
      if (a_done) begin
        chk("a_sum", a_sum, s);
        seen = 1;
        break;
      end
      tick;
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    if (!seen) chk("a_timeout", 1, 0);
    tick;
    tick;
    @(negedge clk);
    chk("a_qempty", qa.size(), 0);
    chk("a_done_cnt", a_dones - d0, 1);
    chk("a_sum_hold", a_sum, s);
    chk("a_idle_addr", a_addr, 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    start_a = 0; start_b = 0; ready_a = 1; ready_b = 1;
    mem_img[0] = 8'h11; mem_img[1] = 8'h22; mem_img[2] = 8'h33; mem_img[3] = 8'h44;
    tick;
    tick;
    @(negedge clk);
    chk("rst_valid", a_valid, 0);
    chk("rst_addr_a", a_addr, 0);
    chk("rst_addr_b", b_addr, 18'h3FFFF);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_sum", a_sum, 0);
    chk("rst_data", a_data, 0);
    reset = 1'b0;
    tick;

    sweep_a(100, 100, 100, 1);  // basic sweep
    sweep_a(3, 5, 100, 0);      // backpressure
    sweep_a(100, 100, 3, 1);    // start while busy ignored

    // reset on cycle 4 aborts with no done
    for (int i = 0; i < 4; i++) qa.push_back({(i == 3), mem_img[i]});
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick; tick; tick;
    reset = 1'b1;
    #1;
    chk("abort_valid", a_valid, 0);
    chk("abort_addr", a_addr, 0);
    chk("abort_busy", a_busy, 0);
    tick;
    reset = 1'b0;
    qa.delete();
    begin
      int d0;
      d0 = a_dones;
      tick; tick; tick;
      @(negedge clk);
      chk("abort_nodone", a_dones - d0, 0);
      chk("abort_idle", a_busy, 0);
    end
    tick;
    sweep_a(100, 100, 100, 1);  // full sequence from 0x11 after abort

    mem_img[0] = 8'hFF; mem_img[1] = 8'hFF; mem_img[2] = 8'hFF; mem_img[3] = 8'hFF;
    sweep_a(100, 100, 100, 1);  // checksum 0x03FC when enabled

    // single pixel at top of memory
    qb.push_back({1'b1, 8'hA5});
    seen = 0;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      chk("b_addr", b_addr, 18'h3FFFF);
      if (b_done) begin
        seen = 1;
        break;
      end
      tick;
    end
    if (!seen) chk("b_timeout", 1, 0);
    tick;
    @(negedge clk);
    chk("b_qempty", qb.size(), 0);
    chk("b_done_cnt", b_dones, 1);
    chk("b_addr_idle", b_addr, 18'h3FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
